// File: rtl/lcd_text_pkg.sv
// Shared constants for the LCD text buffer: control codes, geometry,
// FSM state encoding and the DDRAM address decode helper.
package lcd_text_pkg;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [7:0] LINE2_BASE = 8'h40;
  localparam int         COLS       = 16;
  localparam int         CELLS      = 32;

  localparam logic [1:0] ST_CLEAR   = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_SCROLL  = 2'd2;
  localparam logic [1:0] ST_CLRLINE = 2'd3;

  // True when a DDRAM address lands on a stored cell (0x00-0x0F or 0x40-0x4F).
  // The mapped cell index is then {addr[6], addr[3:0]}.
  function automatic logic addr_mapped(input logic [7:0] addr);
    return (addr[7:4] == 4'h0) || (addr[7:4] == LINE2_BASE[7:4]);
  endfunction

endpackage

// File: rtl/lcd_text_ram.sv
// 32x8 character store: one synchronous write port, two combinational
// read ports (A for the LCD driver, B for the scroll copy source).
module lcd_text_ram
  import lcd_text_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] raddr_a_i,
  output logic [7:0] rdata_a_o,
  input  logic [4:0] raddr_b_i,
  output logic [7:0] rdata_b_o
);

  logic [CELLS-1:0][7:0] mem_q;

  // Cell storage; no reset, the CLEAR sweep initialises it.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/lcd_text_buffer.sv
// 2x16 text buffer for the SC1602 driver. Takes a byte stream over
// valid/ready, handles BS/LF/FF/CR, tracks a cursor and auto-wraps.
// Optional feature macro: LCD_TEXT_BUF_SCROLL_EN -- wrap scrolls line 2 up
// and blanks it; otherwise wrap just homes the cursor.
module lcd_text_buffer
  import lcd_text_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] rd_addr_i,
  input  logic       rd_i,
  output logic [7:0] rd_data_o,
  output logic       busy_o,
  output logic [4:0] cursor_o,
  output logic       frame_done_o
);

  logic [1:0] state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       line_q, line_d;
  logic [3:0] col_q, col_d;
  logic       frame_done_q;

  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic [4:0] raddr_b;
  logic [7:0] rdata_a, rdata_b;
  logic       do_wrap;

  lcd_text_ram u_ram (
    .clk_i     (clk_i),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i ({rd_addr_i[6], rd_addr_i[3:0]}),
    .rdata_a_o (rdata_a),
    .raddr_b_i (raddr_b),
    .rdata_b_o (rdata_b)
  );

  assign in_ready_o   = (state_q == ST_IDLE);
  assign busy_o       = ~in_ready_o;
  assign cursor_o     = {line_q, col_q};
  assign frame_done_o = frame_done_q;
  assign rd_data_o    = addr_mapped(rd_addr_i) ? rdata_a : FILL_CHAR;

`ifndef LCD_TEXT_BUF_SCROLL_EN
  // Port B only feeds the scroll copy, which is absent in this build.
  logic unused_rdata_b;
  assign unused_rdata_b = ^rdata_b;
`endif

  // Next-state: byte interpretation, cursor advance and the fill/copy sweeps.
  // One 5-bit index walks CLEAR (0..31), or SCROLL (0..15) then CLRLINE (16..31).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    line_d  = line_q;
    col_d   = col_q;
    we      = 1'b0;
    waddr   = idx_q;
    wdata   = FILL_CHAR;
    raddr_b = {1'b1, idx_q[3:0]};
    do_wrap = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        we    = 1'b1;
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = ST_IDLE;
          line_d  = 1'b0;
          col_d   = 4'd0;
        end
      end

      ST_IDLE: begin
        if (in_valid_i) begin
          if (in_data_i >= 8'h20) begin
            we    = 1'b1;
            waddr = {line_q, col_q};
            wdata = in_data_i;
            if (col_q != 4'd15) begin
              col_d = col_q + 4'd1;
            end else if (!line_q) begin
              line_d = 1'b1;
              col_d  = 4'd0;
            end else begin
              do_wrap = 1'b1;
            end
          end else begin
            case (in_data_i)
              CH_CR: col_d = 4'd0;
              CH_LF: begin
                col_d = 4'd0;
                if (!line_q) line_d  = 1'b1;
                else         do_wrap = 1'b1;
              end
              CH_FF: begin
                state_d = ST_CLEAR;
                idx_d   = 5'd0;
              end
              CH_BS: if (col_q != 4'd0) col_d = col_q - 4'd1;
              default: ;
            endcase
          end
        end
      end

`ifdef LCD_TEXT_BUF_SCROLL_EN
      ST_SCROLL: begin
        we    = 1'b1;
        waddr = {1'b0, idx_q[3:0]};
        wdata = rdata_b;
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd15) state_d = ST_CLRLINE;
      end

      ST_CLRLINE: begin
        we    = 1'b1;
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = ST_IDLE;
          line_d  = 1'b1;
          col_d   = 4'd0;
        end
      end
`endif

      default: begin
        state_d = ST_CLEAR;
        idx_d   = 5'd0;
      end
    endcase

    if (do_wrap) begin
`ifdef LCD_TEXT_BUF_SCROLL_EN
      state_d = ST_SCROLL;
      idx_d   = 5'd0;
`else
      line_d  = 1'b0;
      col_d   = 4'd0;
`endif
    end
  end

  // State, sweep index and cursor registers; reset restarts the clear sweep.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_CLEAR;
      idx_q   <= 5'd0;
      line_q  <= 1'b0;
      col_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      col_q   <= col_d;
    end
  end

  // Frame marker: pulse the cycle after the driver reads the last cell (0x4F).
  always_ff @(posedge clk_i) begin
    if (reset_i) frame_done_q <= 1'b0;
    else         frame_done_q <= rd_i && (rd_addr_i == 8'h4F);
  end

endmodule
